// File: rtl/serial_adder_stage.sv
// serial_adder_stage: bit-serial full adder. Accepts operand bit pairs LSB-first
// under a valid/ready handshake. Each sum bit is streamed out as it is produced,
// and the WIDTH-bit result plus the final carry are assembled as the bits arrive.
//
// Ports:
//   clk, rst      - clock, synchronous active-high reset
//   ena           - global enable; low freezes all operation state
//   start         - one-cycle pulse that begins or restarts an operation
//   in_valid      - a_bit/b_bit hold a valid operand bit pair
//   a_bit, b_bit  - operand bits, LSB first
//   in_ready      - the stage accepts a bit pair this cycle (RUN and ena)
//   sum_bit       - sum bit of the last accepted pair
//   sum_valid     - one-cycle pulse that marks a new sum_bit
//   result        - assembled sum of the last completed operation
//   carry_out     - final carry of the last completed operation
//   done          - one-cycle pulse; result/carry_out were just updated
//   busy          - high while in RUN
module serial_adder_stage #(
   parameter int unsigned WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             ena,
   input  logic             start,
   input  logic             in_valid,
   input  logic             a_bit,
   input  logic             b_bit,
   output logic             in_ready,
   output logic             sum_bit,
   output logic             sum_valid,
   output logic [WIDTH-1:0] result,
   output logic             carry_out,
   output logic             done,
   output logic             busy
);

   localparam int unsigned CW = $clog2(WIDTH) + 1;

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_RUN  = 2'd1;
   localparam logic [1:0] S_DONE = 2'd2;

   logic [1:0]       state_q, state_d;
   logic             carry_q, carry_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic [WIDTH-1:0] shift_q, shift_d;
   logic             sum_bit_q, sum_bit_d;
   logic             sum_valid_q, sum_valid_d;
   logic [WIDTH-1:0] result_q, result_d;
   logic             carry_out_q, carry_out_d;

   // Full-adder terms for the bit pair that is currently presented
   logic             s;
   logic             c_next;
   logic [WIDTH-1:0] shift_next;

   assign s          = a_bit ^ b_bit ^ carry_q;
   assign c_next     = (a_bit & b_bit) | (a_bit & carry_q) | (b_bit & carry_q);
   assign shift_next = {s, shift_q[WIDTH-1:1]};

   // Next-state and datapath update
   always_comb begin
      state_d     = state_q;
      carry_d     = carry_q;
      cnt_d       = cnt_q;
      shift_d     = shift_q;
      sum_bit_d   = sum_bit_q;
      sum_valid_d = 1'b0;
      result_d    = result_q;
      carry_out_d = carry_out_q;

      if (ena && start) begin
         // start wins over a simultaneous bit pair, in every state
         state_d = S_RUN;
         carry_d = 1'b0;
         cnt_d   = '0;
         shift_d = '0;
      end else begin
         case (state_q)
            S_RUN: begin
               if (ena && in_valid) begin
                  carry_d     = c_next;
                  shift_d     = shift_next;
                  sum_bit_d   = s;
                  sum_valid_d = 1'b1;
                  cnt_d       = cnt_q + CW'(1);
                  if (cnt_q == CW'(WIDTH - 1)) begin
                     state_d     = S_DONE;
                     result_d    = shift_next;
                     carry_out_d = c_next;
                  end
               end
            end
            // DONE lasts one cycle, even when ena is low
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
         endcase
      end
   end

   // State registers
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= S_IDLE;
         carry_q     <= 1'b0;
         cnt_q       <= '0;
         shift_q     <= '0;
         sum_bit_q   <= 1'b0;
         sum_valid_q <= 1'b0;
         result_q    <= '0;
         carry_out_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         carry_q     <= carry_d;
         cnt_q       <= cnt_d;
         shift_q     <= shift_d;
         sum_bit_q   <= sum_bit_d;
         sum_valid_q <= sum_valid_d;
         result_q    <= result_d;
         carry_out_q <= carry_out_d;
      end
   end

   // Status decoded from registered state; in_ready also gated by ena
   assign in_ready  = (state_q == S_RUN) && ena;
   assign busy      = (state_q == S_RUN);
   assign done      = (state_q == S_DONE);
   assign sum_bit   = sum_bit_q;
   assign sum_valid = sum_valid_q;
   assign result    = result_q;
   assign carry_out = carry_out_q;

endmodule

// File: tb/tb_serial_adder_stage.sv
// tb_serial_adder_stage: randomized self-checking bench for serial_adder_stage.
// The reference model is plain integer addition of the operands. Each expected
// sum bit is bit i of a+b.
module tb_serial_adder_stage;

   localparam int unsigned WIDTH = 8;

   logic             clk = 1'b0;
   logic             rst, ena, start, in_valid, a_bit, b_bit;
   logic             in_ready, sum_bit, sum_valid, carry_out, done, busy;
   logic [WIDTH-1:0] result;

   int n_checks = 0;
   int n_errors = 0;

   // Model of the held result/carry_out from the last completed operation
   logic [WIDTH-1:0] m_result = '0;
   logic             m_cout   = 1'b0;

   serial_adder_stage #(.WIDTH(WIDTH)) dut (
      .clk      (clk),
      .rst      (rst),
      .ena      (ena),
      .start    (start),
      .in_valid (in_valid),
      .a_bit    (a_bit),
      .b_bit    (b_bit),
      .in_ready (in_ready),
      .sum_bit  (sum_bit),
      .sum_valid(sum_valid),
      .result   (result),
      .carry_out(carry_out),
      .done     (done),
      .busy     (busy)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Called at a negedge. Returns at the negedge of the DONE cycle.
   // mode: 0 continuous, 1 alternate gaps, 2 random gaps, 3 ena freeze after 3 bits
   task automatic run_op(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                         input int mode, input string tag);
      logic [WIDTH:0] expsum;
      int acc, cyc, frz;
      bit v;
      expsum = {1'b0, a} + {1'b0, b};
      acc = 0; cyc = 0; frz = 0;
      // start with a junk pair alongside; start must win
      ena = 1'b1; start = 1'b1; in_valid = 1'b1;
      a_bit = 1'b1; b_bit = 1'b1;
      @(negedge clk);
      start = 1'b0;
      check({tag, ":start_sv"}, 32'(sum_valid), 32'd0);
      check({tag, ":start_busy"}, 32'(busy), 32'd1);
      check({tag, ":start_held"}, 32'({carry_out, result}), 32'({m_cout, m_result}));
      while (acc < WIDTH && cyc < 100) begin
         check({tag, ":ready"}, 32'(in_ready), 32'(ena));
         case (mode)
            1:       in_valid = (cyc % 2 == 0);
            2:       in_valid = 1'($urandom_range(0, 1));
            default: in_valid = 1'b1;
         endcase
         ena = !(mode == 3 && acc == 3 && frz < 5);
         if (!ena) frz++;
         a_bit = a[acc];
         b_bit = b[acc];
         v = in_valid && ena;
         @(negedge clk);
         cyc++;
         check({tag, ":sv"}, 32'(sum_valid), 32'(v));
         if (v) begin
            check({tag, ":bit"}, 32'(sum_bit), 32'(expsum[acc]));
            acc++;
         end
         if (acc < WIDTH) check({tag, ":early_done"}, 32'(done), 32'd0);
      end
      in_valid = 1'b0;
      ena      = 1'b1;
      check({tag, ":accepts"}, 32'(acc), WIDTH);
      check({tag, ":done"}, 32'(done), 32'd1);
      check({tag, ":done_busy"}, 32'(busy), 32'd0);
      check({tag, ":done_ready"}, 32'(in_ready), 32'd0);
      m_result = expsum[WIDTH-1:0];
      m_cout   = expsum[WIDTH];
      check({tag, ":result"}, 32'(result), 32'(m_result));
      check({tag, ":cout"}, 32'(carry_out), 32'(m_cout));
   endtask

   // Start an operation and feed n bits; leaves the DUT in RUN
   task automatic partial(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                          input int n, input string tag);
      logic [WIDTH:0] expsum;
      expsum = {1'b0, a} + {1'b0, b};
      ena = 1'b1; start = 1'b1; in_valid = 1'b0;
      @(negedge clk);
      start = 1'b0;
      for (int i = 0; i < n; i++) begin
         in_valid = 1'b1; a_bit = a[i]; b_bit = b[i];
         @(negedge clk);
         check({tag, ":p_sv"}, 32'(sum_valid), 32'd1);
         check({tag, ":p_bit"}, 32'(sum_bit), 32'(expsum[i]));
         check({tag, ":p_done"}, 32'(done), 32'd0);
      end
      in_valid = 1'b0;
   endtask

   // One cycle with no activity; after DONE the DUT must be back in IDLE
   task automatic idle(input string tag);
      @(negedge clk);
      check({tag, ":idle_done"}, 32'(done), 32'd0);
      check({tag, ":idle_busy"}, 32'(busy), 32'd0);
      check({tag, ":idle_ready"}, 32'(in_ready), 32'd0);
      check({tag, ":idle_result"}, 32'(result), 32'(m_result));
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, ":rst_ready"}, 32'(in_ready), 32'd0);
      check({tag, ":rst_sumbit"}, 32'(sum_bit), 32'd0);
      check({tag, ":rst_sv"}, 32'(sum_valid), 32'd0);
      check({tag, ":rst_result"}, 32'(result), 32'd0);
      check({tag, ":rst_cout"}, 32'(carry_out), 32'd0);
      check({tag, ":rst_done"}, 32'(done), 32'd0);
      check({tag, ":rst_busy"}, 32'(busy), 32'd0);
   endtask

   initial begin
      rst = 1'b1; ena = 1'b0; start = 1'b0; in_valid = 1'b0; a_bit = 1'b0; b_bit = 1'b0;
      repeat (3) @(negedge clk);
      check_reset_outputs("por");
      rst = 1'b0;
      idle("por");

      // Directed cases
      run_op(8'h5A, 8'h3C, 0, "5a3c");
      idle("5a3c");
      run_op(8'hFF, 8'h01, 0, "ff01");
      run_op(8'hFF, 8'hFF, 0, "ffff_b2b");
      idle("ffff");
      run_op(8'h0F, 8'h01, 1, "gaps");
      idle("gaps");

      // Abort: restart mid-operation, the prior result stays held
      partial(8'hAA, 8'h55, 4, "abort");
      run_op(8'h01, 8'h02, 0, "abort_new");
      idle("abort");

      // ena freeze mid-operation
      run_op(8'h5A, 8'h3C, 3, "freeze");
      idle("freeze");

      // Reset mid-operation, then stray pairs without a start
      partial(8'h37, 8'h99, 3, "midrst");
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      m_result = '0; m_cout = 1'b0;
      check_reset_outputs("midrst");
      in_valid = 1'b1; a_bit = 1'b1; b_bit = 1'b0;
      repeat (3) begin
         @(negedge clk);
         check("midrst:ignored_sv", 32'(sum_valid), 32'd0);
         check("midrst:ignored_busy", 32'(busy), 32'd0);
      end
      in_valid = 1'b0;

      // Randomized operations with random gaps and back-to-back starts
      for (int k = 0; k < 20; k++) begin
         run_op(WIDTH'($urandom), WIDTH'($urandom), int'($urandom_range(0, 3)), "rand");
         if ($urandom_range(0, 1) == 1) idle("rand");
      end
      idle("rand_end");

      // rst has priority over start
      rst = 1'b1; start = 1'b1; ena = 1'b1;
      @(negedge clk);
      rst = 1'b0; start = 1'b0;
      m_result = '0; m_cout = 1'b0;
      check_reset_outputs("rst_prio");

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
